// File: rtl/a_skew_feeder.sv
// a_skew_feeder: row-buffered A-operand feeder; streams the stored matrix into the array with row r delayed r cycles.
// Latency: first slice one enabled edge after start; 2*DIM-1 valid slices, then a one-cycle done pulse.
// Backpressure: en=0 freezes Aout/valid/t exactly (no bubbles). Optional A_SKEW_FEEDER_AUTOCLEAR_EN clears the buffer on DONE->IDLE.
module a_skew_feeder #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      WrEn,
    input  logic [$clog2(DIM)-1:0]    Arow,
    input  logic signed [BITS_AB-1:0] Ain  [DIM],
    input  logic                      start,
    input  logic                      en,
    output logic signed [BITS_AB-1:0] Aout [DIM],
    output logic                      valid,
    output logic                      busy,
    output logic                      done
);

    localparam int TW = $clog2(2*DIM);
    localparam logic [TW-1:0] T_LAST = TW'(2*DIM-2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [TW-1:0]             t;
    logic signed [BITS_AB-1:0] abuf  [DIM][DIM];
    logic signed [BITS_AB-1:0] slice [DIM];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = STREAM;
            STREAM:  if (en && (t == T_LAST)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Row r sees column t-r; selecting by r+c==t avoids a subtract-and-range-check per row.
    always_comb begin
        for (int r = 0; r < DIM; r++) begin
            slice[r] = '0;
            for (int c = 0; c < DIM; c++) begin
                if (int'(t) == r + c) slice[r] = abuf[r][c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            t     <= '0;
            valid <= 1'b0;
            for (int r = 0; r < DIM; r++) begin
                Aout[r] <= '0;
                for (int c = 0; c < DIM; c++) abuf[r][c] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        t <= '0;
                    end else if (WrEn) begin
                        for (int c = 0; c < DIM; c++) abuf[Arow][c] <= Ain[c];
                    end
                end
                STREAM: begin
                    if (en) begin
                        for (int r = 0; r < DIM; r++) Aout[r] <= slice[r];
                        valid <= 1'b1;
                        t     <= t + 1'b1;
                    end
                end
                DONE: begin
                    for (int r = 0; r < DIM; r++) Aout[r] <= '0;
                    valid <= 1'b0;
`ifdef A_SKEW_FEEDER_AUTOCLEAR_EN
                    for (int r = 0; r < DIM; r++) begin
                        for (int c = 0; c < DIM; c++) abuf[r][c] <= '0;
                    end
`else
                    t <= t;
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_a_skew_feeder.sv
// Self-checking bench for a_skew_feeder (DIM=8, 8-bit operands); expected slices come from a bench-side buffer model.
module tb_a_skew_feeder;
    localparam int DIM  = 8;
    localparam int BITS = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   WrEn;
    logic [2:0]             Arow;
    logic signed [BITS-1:0] Ain  [DIM];
    logic                   start;
    logic                   en;
    logic signed [BITS-1:0] Aout [DIM];
    logic                   valid;
    logic                   busy;
    logic                   done;

    int checks = 0;
    int errors = 0;

    logic signed [BITS-1:0] m [DIM][DIM];
    logic [DIM*BITS-1:0]    exp_q [$];
    logic [DIM*BITS-1:0]    slice3;

    a_skew_feeder #(.BITS_AB(BITS), .DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n), .WrEn(WrEn), .Arow(Arow), .Ain(Ain),
        .start(start), .en(en), .Aout(Aout), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [DIM*BITS-1:0] model_slice(input int t);
        logic [DIM*BITS-1:0] v;
        v = '0;
        for (int r = 0; r < DIM; r++)
            if (t >= r && t < r + DIM) v[r*BITS +: BITS] = m[r][t-r];
        return v;
    endfunction

    function automatic logic [DIM*BITS-1:0] pack_aout();
        logic [DIM*BITS-1:0] v;
        for (int r = 0; r < DIM; r++) v[r*BITS +: BITS] = Aout[r];
        return v;
    endfunction

    task automatic clear_model();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) m[r][c] = '0;
    endtask

    // mode 0: 8r+c, mode 1: alternating -128/127 by column
    task automatic load_matrix(input int mode);
        for (int r = 0; r < DIM; r++) begin
            @(negedge clk);
            WrEn = 1'b1;
            Arow = r[2:0];
            for (int c = 0; c < DIM; c++) begin
                if (mode == 0) Ain[c] = 8'(8*r + c);
                else           Ain[c] = (c % 2 == 0) ? -8'sd128 : 8'sd127;
                m[r][c] = Ain[c];
            end
        end
        @(negedge clk);
        WrEn = 1'b0;
    endtask

    task automatic run_stream(input int stall_at, input int stall_len,
                              input bit wr_with_start, input bit wr_during,
                              output int vcount);
        int  n = 0;
        int  stalled = 0;
        int  done_cnt = 0;
        bit  en_now;
        bit  done_seen = 0;
        bit  fin = 0;
        logic [DIM*BITS-1:0] last = '0;
        logic [DIM*BITS-1:0] got;
        logic [DIM*BITS-1:0] expv;
        vcount = 0;
        for (int t = 0; t < 2*DIM-1; t++) exp_q.push_back(model_slice(t));
        @(negedge clk);
        start = 1'b1;
        if (wr_with_start) begin
            WrEn = 1'b1;
            Arow = 3'd1;
            for (int c = 0; c < DIM; c++) Ain[c] = 8'sh55;
        end
        @(negedge clk);
        start = 1'b0;
        WrEn  = 1'b0;
        for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
            en_now = !(n == stall_at && stalled < stall_len);
            if (!en_now) stalled++;
            en = en_now;
            if (wr_during && cyc == 2) begin
                WrEn = 1'b1;
                Arow = 3'd2;
                for (int c = 0; c < DIM; c++) Ain[c] = 8'sh55;
            end else begin
                WrEn = 1'b0;
            end
            @(negedge clk);
            got = pack_aout();
            if (done_seen && !done) begin
                fin = 1;
                checks++;
                if (busy !== 1'b0 || valid !== 1'b0) begin
                    errors++;
                    $display("FAIL post_done busy=%b valid=%b required busy=0 valid=0", busy, valid);
                end
            end else if (valid) begin
                vcount++;
                if (en_now) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_slice got=%h required no slice", got);
                    end else begin
                        expv = exp_q.pop_front();
                        if (got !== expv) begin
                            errors++;
                            $display("FAIL slice t=%0d got=%h required=%h", n, got, expv);
                        end
                        if (n == 3) slice3 = got;
                        last = expv;
                        n++;
                    end
                end else begin
                    checks++;
                    if (got !== last) begin
                        errors++;
                        $display("FAIL stall_hold got=%h required=%h", got, last);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (n != 2*DIM-1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL done_timing slices=%0d busy=%b required slices=%0d busy=1", n, busy, 2*DIM-1);
                end
            end
            done_seen = done_seen | (done === 1'b1);
        end
        WrEn = 1'b0;
        en   = 1'b1;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL stream_timeout slices=%0d required completion", n);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL done_count got=%0d required=1", done_cnt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_slices left=%0d required=0", exp_q.size());
            exp_q.delete();
        end
`ifdef A_SKEW_FEEDER_AUTOCLEAR_EN
        clear_model();
`endif
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (pack_aout() !== '0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s Aout=%h valid=%b busy=%b done=%b required all 0",
                     name, pack_aout(), valid, busy, done);
        end
    endtask

    task automatic test_reset();
        int vc;
        #1 check_zero("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;
        load_matrix(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        en = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid got=%b required=1", valid);
        end
        #2 rst_n = 1'b0;
        #1 check_zero("reset_midstream");
        @(negedge clk);
        check_zero("reset_held");
        rst_n = 1'b1;
        clear_model();
        run_stream(-1, 0, 0, 0, vc);
        checks++;
        if (vc != 2*DIM-1) begin
            errors++;
            $display("FAIL reset_stream_len got=%0d required=%0d", vc, 2*DIM-1);
        end
    endtask

    task automatic test_identity();
        int vc;
        logic [DIM*BITS-1:0] e3;
        e3 = {8'd0, 8'd0, 8'd0, 8'd0, 8'd24, 8'd17, 8'd10, 8'd3};
        load_matrix(0);
        run_stream(-1, 0, 0, 0, vc);
        checks++;
        if (vc != 2*DIM-1) begin
            errors++;
            $display("FAIL identity_len got=%0d required=%0d", vc, 2*DIM-1);
        end
        checks++;
        if (slice3 !== e3) begin
            errors++;
            $display("FAIL identity_t3 got=%h required=%h", slice3, e3);
        end
    endtask

    task automatic test_stall();
        int vc;
        load_matrix(0);
        run_stream(5, 3, 0, 0, vc);
        checks++;
        if (vc != 2*DIM-1+3) begin
            errors++;
            $display("FAIL stall_len got=%0d required=%0d", vc, 2*DIM-1+3);
        end
    endtask

    task automatic test_sign();
        int vc;
        load_matrix(1);
        run_stream(-1, 0, 0, 0, vc);
        checks++;
        if (vc != 2*DIM-1) begin
            errors++;
            $display("FAIL sign_len got=%0d required=%0d", vc, 2*DIM-1);
        end
    endtask

    task automatic test_priority();
        int vc;
        load_matrix(0);
        run_stream(-1, 0, 1, 1, vc);
        run_stream(-1, 0, 0, 0, vc);
    endtask

    task automatic test_replay();
        int vc;
        load_matrix(1);
        run_stream(-1, 0, 0, 0, vc);
        run_stream(-1, 0, 0, 0, vc);
        checks++;
        if (vc != 2*DIM-1) begin
            errors++;
            $display("FAIL replay_len got=%0d required=%0d", vc, 2*DIM-1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        WrEn  = 1'b0;
        start = 1'b0;
        en    = 1'b1;
        Arow  = '0;
        for (int c = 0; c < DIM; c++) Ain[c] = '0;
        clear_model();
        test_reset();
        test_identity();
        test_stall();
        test_sign();
        test_priority();
        test_replay();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1, "timeout");
    end
endmodule
